// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 16-bit ALU: takes one op over valid/ready, drives the
// registered ALU inputs, waits for the addressed unit's flag and returns one widened result.
module alu_cmd_sequencer #(
  parameter int OP_DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [OP_DATA_WIDTH-1:0]   req_a,
  input  logic [OP_DATA_WIDTH-1:0]   req_b,
  input  logic [3:0]                 req_fun,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [2*OP_DATA_WIDTH-1:0] resp_data,
  output logic                       resp_carry,
  output logic [1:0]                 resp_unit,
  output logic                       resp_err,
  output logic [OP_DATA_WIDTH-1:0]   alu_a,
  output logic [OP_DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]                 alu_fun,
  input  logic [2*OP_DATA_WIDTH-1:0] arith_out,
  input  logic                       carry_out,
  input  logic                       arith_flag,
  input  logic [OP_DATA_WIDTH-1:0]   logic_out,
  input  logic                       logic_flag,
  input  logic [2:0]                 cmp_out,
  input  logic                       cmp_flag,
  input  logic [OP_DATA_WIDTH-1:0]   shift_out,
  input  logic                       shift_flag
);

  localparam int W     = OP_DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             unit_flag;
  logic             unit_carry;
  logic [2*W-1:0]   unit_data;

  // Result mux keyed on the latched function, never on the live request.
  always_comb begin
    unit_flag  = 1'b0;
    unit_carry = 1'b0;
    unit_data  = '0;
    case (alu_fun[3:2])
      2'b00: begin
        unit_flag  = arith_flag;
        unit_data  = arith_out;
        unit_carry = carry_out;
      end
      2'b01: begin
        unit_flag = logic_flag;
        unit_data = {{W{1'b0}}, logic_out};
      end
      2'b10: begin
        unit_flag = cmp_flag;
        unit_data = {{(2*W-3){1'b0}}, cmp_out};
      end
      default: begin
        unit_flag = shift_flag;
        unit_data = {{W{1'b0}}, shift_out};
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_carry <= 1'b0;
      resp_unit  <= 2'b00;
      resp_err   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_fun   <= req_fun;
            cnt       <= '0;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        // Flags are not looked at here: the previous op's flag may still be high.
        ISSUE: state <= WAIT;
        WAIT: begin
          if (unit_flag) begin
            resp_valid <= 1'b1;
            resp_data  <= unit_data;
            resp_carry <= unit_carry;
            resp_unit  <= alu_fun[3:2];
            resp_err   <= 1'b0;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_carry <= 1'b0;
              resp_unit  <= alu_fun[3:2];
              resp_err   <= 1'b1;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a small registered ALU model feeds the unit ports and a
// scoreboard of spec-level expected responses is compared against the DUT every valid cycle.
module tb_alu_cmd_sequencer;
  localparam int W = 16;
  localparam int T = 4;

  logic          CLK, RST;
  logic          req_valid, req_ready, resp_valid, resp_ready;
  logic [W-1:0]  req_a, req_b, alu_a, alu_b;
  logic [3:0]    req_fun, alu_fun;
  logic [2*W-1:0] resp_data, arith_out;
  logic          resp_carry, resp_err, carry_out, arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [1:0]    resp_unit;
  logic [W-1:0]  logic_out, shift_out;
  logic [2:0]    cmp_out;
  logic          logic_dead;

  alu_cmd_sequencer #(.OP_DATA_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_carry(resp_carry), .resp_unit(resp_unit), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .carry_out(carry_out), .arith_flag(arith_flag),
    .logic_out(logic_out), .logic_flag(logic_flag),
    .cmp_out(cmp_out), .cmp_flag(cmp_flag),
    .shift_out(shift_out), .shift_flag(shift_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU stand-in: every unit recomputes from the registered inputs each edge, so outputs lag
  // alu_* by one edge and flags stay high (stale) between ops.
  logic [2*W-1:0] arith_n;
  logic           carry_n;
  logic [W-1:0]   logic_n, shift_n;
  logic [2:0]     cmp_n;
  logic [W:0]     sum17, diff17;

  always_comb begin
    arith_n = '0; carry_n = 1'b0; logic_n = '0; shift_n = '0; cmp_n = '0;
    sum17   = {1'b0, alu_a} + {1'b0, alu_b};
    diff17  = {1'b0, alu_a} - {1'b0, alu_b};
    case (alu_fun[1:0])
      2'd0: begin arith_n = {16'h0, sum17[W-1:0]};  carry_n = sum17[W];  end
      2'd1: begin arith_n = {16'h0, diff17[W-1:0]}; carry_n = diff17[W]; end
      2'd2: arith_n = 32'(alu_a) * 32'(alu_b);
      default: arith_n = '0;
    endcase
    case (alu_fun[1:0])
      2'd0: logic_n = alu_a & alu_b;
      2'd1: logic_n = alu_a | alu_b;
      2'd2: logic_n = alu_a ^ alu_b;
      default: logic_n = ~(alu_a | alu_b);
    endcase
    case (alu_fun[1:0])
      2'd0: shift_n = alu_a << alu_b[3:0];
      2'd1: shift_n = alu_a >> alu_b[3:0];
      default: shift_n = alu_a;
    endcase
    cmp_n = {alu_a < alu_b, alu_a > alu_b, alu_a == alu_b};
  end

  always @(posedge CLK) begin
    arith_out  <= RST ? arith_n : '0;
    carry_out  <= RST ? carry_n : 1'b0;
    logic_out  <= RST ? logic_n : '0;
    cmp_out    <= RST ? cmp_n : '0;
    shift_out  <= RST ? shift_n : '0;
    arith_flag <= RST;
    cmp_flag   <= RST;
    shift_flag <= RST;
    logic_flag <= RST && !logic_dead;
  end

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic [1:0]  unit;
    logic        err;
    int          lat;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // What the master must see for an op, from the ALU semantics and the sequencer's rules.
  function automatic exp_t model(input longint a, input longint b, input logic [3:0] fun, input bit dead);
    exp_t   e;
    longint r;
    int     sh;
    e.data = '0; e.carry = 1'b0; e.unit = fun[3:2]; e.err = 1'b0; e.lat = 2;
    sh = int'(b % 16);
    case (fun[3:2])
      2'b00: case (fun[1:0])
        2'd0: begin r = a + b; e.data = 32'(r % 65536); e.carry = (r > 65535); end
        2'd1: begin e.data = 32'((a - b + 65536) % 65536); e.carry = (a < b); end
        2'd2: e.data = 32'(a * b);
        default: e.data = '0;
      endcase
      2'b01: if (dead) begin
        e.err = 1'b1; e.lat = T + 1;
      end else case (fun[1:0])
        2'd0: e.data = 32'(a & b);
        2'd1: e.data = 32'(a | b);
        2'd2: e.data = 32'(a ^ b);
        default: e.data = 32'(65535 - (a | b));
      endcase
      2'b10: e.data = (a < b) ? 32'd4 : (a > b) ? 32'd2 : 32'd1;
      default: case (fun[1:0])
        2'd0: e.data = 32'((a << sh) % 65536);
        2'd1: e.data = 32'(a >> sh);
        default: e.data = 32'(a);
      endcase
    endcase
    return e;
  endfunction

  // Every cycle a response is up it must match the head of the scoreboard; none may appear unasked.
  always @(negedge CLK) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_resp", 64'(resp_valid), 64'd0);
      else begin
        chk("resp_data",  64'(resp_data),  64'(exp_q[0].data));
        chk("resp_carry", 64'(resp_carry), 64'(exp_q[0].carry));
        chk("resp_unit",  64'(resp_unit),  64'(exp_q[0].unit));
        chk("resp_err",   64'(resp_err),   64'(exp_q[0].err));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                          output bit ok);
    int n;
    @(posedge CLK); #1;
    req_a = a; req_b = b; req_fun = fun; req_valid = 1'b1;
    n = 0; ok = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (req_ready !== 1'b1 && n < 20);
    if (req_ready !== 1'b1) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      ok = 1'b0;
    end else @(posedge CLK);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                       input int hold, input bit pre_ready, input bit wiggle,
                       input logic [31:0] lit_data, input bit lit_err);
    exp_t e;
    bit   ok;
    int   n;
    e = model(longint'(a), longint'(b), fun, logic_dead);
    send_req(a, b, fun, ok);
    if (!ok) return;
    exp_q.push_back(e);
    #1;
    if (wiggle) req_a = a ^ 16'h5a5a; else req_valid = 1'b0;
    if (pre_ready) resp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (wiggle && resp_valid !== 1'b1) req_a = 16'($urandom);
    end while (resp_valid !== 1'b1 && n < 20);
    if (resp_valid !== 1'b1) begin
      chk("resp_timeout", 64'(resp_valid), 64'd1);
      void'(exp_q.pop_back());
      req_valid = 1'b0; resp_ready = 1'b0;
      return;
    end
    chk("latency",        64'(n - 1),     64'(e.lat));
    chk("lit_data",       64'(resp_data), 64'(lit_data));
    chk("lit_err",        64'(resp_err),  64'(lit_err));
    chk("alu_a_held",     64'(alu_a),     64'(a));
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    if (!pre_ready) begin
      repeat (hold) begin
        @(negedge CLK);
        chk("resp_held", 64'(resp_valid), 64'd1);
      end
      @(posedge CLK); #1 resp_ready = 1'b1;
    end
    @(posedge CLK); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    @(negedge CLK);
    chk("resp_drop",  64'(resp_valid), 64'd0);
    chk("ready_back", 64'(req_ready),  64'd1);
  endtask

  initial begin
    bit ok;
    RST = 1'b0; req_valid = 1'b1; resp_ready = 1'b0; logic_dead = 1'b0;
    req_a = 16'h1234; req_b = 16'h5678; req_fun = 4'h3;
    repeat (3) @(negedge CLK);
    chk("rst_req_ready",  64'(req_ready),  64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data",  64'(resp_data),  64'd0);
    chk("rst_resp_flags", 64'({resp_carry, resp_unit, resp_err}), 64'd0);
    chk("rst_alu",        64'({alu_a, alu_b, alu_fun}), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1; req_valid = 1'b0;

    do_op(16'd3,     16'd5,     4'b0000, 0, 1'b1, 1'b0, 32'd8,          1'b0);
    do_op(16'hFFFF,  16'd2,     4'b0000, 0, 1'b1, 1'b0, 32'd1,          1'b0);
    do_op(16'h0100,  16'h0100,  4'b0010, 5, 1'b0, 1'b0, 32'h0001_0000,  1'b0);
    do_op(16'd7,     16'd3,     4'b1010, 0, 1'b1, 1'b0, 32'd2,          1'b0);
    do_op(16'd4,     16'd4,     4'b1001, 0, 1'b1, 1'b0, 32'd1,          1'b0);
    logic_dead = 1'b1;
    do_op(16'hF0F0,  16'hFF00,  4'b0100, 2, 1'b0, 1'b0, 32'd0,          1'b1);
    logic_dead = 1'b0;
    do_op(16'hF0F0,  16'hFF00,  4'b0100, 0, 1'b1, 1'b0, 32'h0000_F000,  1'b0);
    do_op(16'h8000,  16'd4,     4'b1101, 0, 1'b1, 1'b0, 32'h0000_0800,  1'b0);
    do_op(16'd10,    16'd3,     4'b0001, 0, 1'b1, 1'b1, 32'd7,          1'b0);

    // Reset lands on the edge where the shift op sits in WAIT; no response may follow.
    send_req(16'h0001, 16'd3, 4'b1100, ok);
    if (ok) begin
      #1 req_valid = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK); #1 RST = 1'b1;
      @(negedge CLK);
      chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
      chk("midrst_alu_fun",    64'(alu_fun),    64'd0);
      @(negedge CLK);
      chk("midrst_ready",      64'(req_ready),  64'd1);
      repeat (6) @(negedge CLK);
    end

    do_op(16'hFF00,  16'h0FF0,  4'b0110, 1, 1'b0, 1'b0, 32'h0000_F0F0,  1'b0);
    repeat (10) @(negedge CLK);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side driver for the 16-bit ALU. It accepts one operation at a time over a valid/ready request channel and drives the ALU operand and function inputs. It waits for the registered result flag of the addressed unit, then returns a single unified, zero-extended result over a valid/ready response channel. It sits between a bus/CPU-side master and the ALU top, sharing the ALU's clock and reset.

## Interface
- OP_DATA_WIDTH, 16, operand width; must match the ALU.
- TIMEOUT_CYCLES, 4, maximum WAIT cycles for the unit flag before an error response; must be ≥1.

- CLK  in  1  clock, rising-edge.
- RST  in  1  synchronous reset, active-low; same net as the ALU reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  OP_DATA_WIDTH  operand A.
- req_b  in  OP_DATA_WIDTH  operand B.
- req_fun  in  4  ALU function; [3:2] selects the unit (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] selects the sub-op.
- resp_valid  out  1  response present.
- resp_ready  in  1  master accepts the response.
- resp_data  out  2*OP_DATA_WIDTH  result, zero-extended.
- resp_carry  out  1  arithmetic carry; 0 for other units.
- resp_unit  out  2  copy of req_fun[3:2] for this op.
- resp_err  out  1  timeout; resp_data=0 when set.
- alu_a, alu_b  out  OP_DATA_WIDTH  ALU operands, registered.
- alu_fun  out  4  ALU function, registered.
- arith_out  in  2*OP_DATA_WIDTH; carry_out, arith_flag  in  1.
- logic_out  in  OP_DATA_WIDTH; logic_flag  in  1.
- cmp_out  in  3; cmp_flag  in  1.
- shift_out  in  OP_DATA_WIDTH; shift_flag  in  1.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Encoding is free.
- **IDLE**
  - req_ready = 1 (gated by RST=1).
  - On req_valid: latch req_a/req_b/req_fun into alu_a/alu_b/alu_fun, clear the timeout counter, and go to ISSUE.
- **ISSUE**
  - One cycle. The ALU samples the new inputs at the end of this cycle.
  - Unit flags are ignored here, because a stale flag from the previous op may still be high.
  - Always goes to WAIT.
- **WAIT**
  - Samples the flag selected by alu_fun[3:2].
  - Flag high: capture the result and go to RESP.
    - arith: resp_data=arith_out, resp_carry=carry_out.
    - logic, shift: resp_data={zeros, out}, resp_carry=0.
    - cmp: resp_data={zeros, cmp_out}, resp_carry=0.
    - In all cases resp_unit=alu_fun[3:2] and resp_err=0.
  - Flag low: increment the counter. When the counter reaches TIMEOUT_CYCLES, go to RESP with resp_err=1, resp_data=0, resp_carry=0.
- **RESP**
  - resp_valid = 1 and response fields are held stable until resp_ready is seen high at an edge; then go to IDLE.
- Flags of non-selected units are ignored.
- alu_a/alu_b/alu_fun hold their last values outside IDLE capture. They are never changed mid-operation.
- Counter width is clog2(TIMEOUT_CYCLES+1).

## Timing
- **Reset:** while RST=0 at an edge:
  - state → IDLE.
  - req_ready, resp_valid, resp_data, resp_carry, resp_unit, resp_err, alu_a, alu_b, alu_fun all → 0.
  - req_ready is forced 0 during reset.
- **Request handshake:** a request is accepted at edge E0 with req_valid=1 and req_ready=1. req_ready drops the cycle after E0.
- **Nominal latency:**
  - E0 accept → ISSUE; the ALU registers at E1 → WAIT; the flag is seen at E2 → RESP.
  - resp_valid is high from E2, i.e. 2 cycles after acceptance.
  - Minimum op period is 4 cycles: E0 accept, E3 response taken when resp_ready=1, IDLE after E3, next accept at E4.
- **Timeout:** the error response is asserted TIMEOUT_CYCLES+1 edges after E0.
- **Response handshake:** resp_valid stays high through any number of resp_ready=0 cycles with fields unchanged. It drops the cycle after the accepting edge.
- **Request during busy:** req_valid while not in IDLE is not accepted. The request inputs are ignored and the master must hold them.
- **Simultaneous events:**
  - resp_ready taken in RESP and a new req_valid in the same cycle: no bypass. The request is accepted at the next edge, from IDLE.
  - Reset low coincident with any handshake: reset wins and the op is dropped with no response.
- **Reset mid-operation** (ISSUE/WAIT/RESP): the pending op is discarded and resp_valid → 0 at that edge.

## Test plan
- **Add:** req_fun=0000, A=3, B=5, resp_ready=1 → resp_valid high 2 cycles after accept, resp_data=32'd8, resp_unit=00, resp_err=0.
- **Multiply width and backpressure:** req_fun=0010, A=16'h0100, B=16'h0100, resp_ready=0 for 5 cycles → resp_data=32'h0001_0000 held stable all 5 cycles; resp_valid drops the cycle after resp_ready=1.
- **Compare zero-extension and stale-flag rejection:** back-to-back cmp ops. First req_fun=1010, A=7, B=3 → resp_data=32'd2. Second req_fun=1001, A=4, B=4 → resp_data=32'd1, not a stale 2.
- **Timeout:** bench ALU model holds logic_flag=0, req_fun=0100 → resp_err=1, resp_data=0 exactly TIMEOUT_CYCLES+1 edges after accept; next request completes normally.
- **Reset mid-op:** RST=0 for one edge while in WAIT after a shift request → resp_valid never asserts for that op, alu_fun=0, req_ready=1 the cycle after RST returns high.
- **Busy-ignore:** req_valid held high with changing req_a during ISSUE/WAIT/RESP → only the value present at IDLE acceptance reaches alu_a.
